// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Bus type, FSM states and access-size encodings.
package mem_port_arbiter_pkg;

  typedef logic [31:0] dataBus_t;

  typedef enum logic [1:0] {
    IDLE,
    I_REQ,
    D_REQ,
    RESP
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and unified memory port signals.
// slave: the arbiter; master: requesters plus memory model.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic       i_inst_rd_en;
  dataBus_t   i_inst_addr;
  logic       o_instr_ready;
  dataBus_t   o_instr_data;

  logic       i_data_rd_en;
  logic       i_data_wr_en;
  logic [1:0] i_data_ctrl;
  dataBus_t   i_data_addr;
  dataBus_t   i_data_wr;
  logic       o_data_ready;
  dataBus_t   o_data_rd;

  logic       o_mem_req;
  logic       o_mem_we;
  logic [1:0] o_mem_ctrl;
  dataBus_t   o_mem_addr;
  dataBus_t   o_mem_wdata;
  logic       i_mem_ack;
  dataBus_t   i_mem_rdata;

  modport slave (
    input  i_inst_rd_en, i_inst_addr,
    input  i_data_rd_en, i_data_wr_en,
    input  i_data_ctrl, i_data_addr, i_data_wr,
    input  i_mem_ack, i_mem_rdata,
    output o_instr_ready, o_instr_data,
    output o_data_ready, o_data_rd,
    output o_mem_req, o_mem_we, o_mem_ctrl,
    output o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_inst_rd_en, i_inst_addr,
    output i_data_rd_en, i_data_wr_en,
    output i_data_ctrl, i_data_addr, i_data_wr,
    output i_mem_ack, i_mem_rdata,
    input  o_instr_ready, o_instr_data,
    input  o_data_ready, o_data_rd,
    input  o_mem_req, o_mem_we, o_mem_ctrl,
    input  o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one memory port, one txn at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  io_bus
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic       r_win_d;
  logic       r_mem_we;
  logic [1:0] r_mem_ctrl;
  dataBus_t   r_mem_addr;
  dataBus_t   r_mem_wdata;
  dataBus_t   r_instr_data;
  dataBus_t   r_data_rd;

  logic       w_d_pend;
  logic       w_i_pend;
  logic       w_grant;
  logic       w_grant_d;
  logic       w_ack;

  assign w_d_pend = io_bus.i_data_rd_en | io_bus.i_data_wr_en;
  assign w_i_pend = io_bus.i_inst_rd_en;
  assign w_grant  = (r_state == IDLE) & (w_d_pend | w_i_pend);
  assign w_ack    = io_bus.i_mem_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On contention, favour whoever lost the previous grant.
  always_comb begin
    w_grant_d = w_d_pend & (~w_i_pend | ~r_last_d);
  end

  // Remember the last winner; reset favours data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Data always wins over fetch.
  always_comb begin
    w_grant_d = w_d_pend;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: grant from IDLE, wait for ack, one RESP cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = D_REQ;
        end else if (w_i_pend) begin
          w_next = I_REQ;
        end
      end
      I_REQ, D_REQ: begin
        if (w_ack) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's request fields at grant time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_d     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_ctrl  <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant) begin
      r_win_d <= w_grant_d;
      if (w_grant_d) begin
        r_mem_we    <= io_bus.i_data_wr_en;
        r_mem_ctrl  <= io_bus.i_data_ctrl;
        r_mem_addr  <= io_bus.i_data_addr;
        r_mem_wdata <= io_bus.i_data_wr;
      end else begin
        r_mem_we    <= 1'b0;
        r_mem_ctrl  <= SZ_WORD;
        r_mem_addr  <= io_bus.i_inst_addr;
        r_mem_wdata <= '0;
      end
    end
  end

  // Capture read data into the winner's output on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_data <= '0;
      r_data_rd    <= '0;
    end else if (w_ack) begin
      if (r_state == I_REQ) begin
        r_instr_data <= io_bus.i_mem_rdata;
      end
      if (r_state == D_REQ) begin
        r_data_rd <= io_bus.i_mem_rdata;
      end
    end
  end

  // Outputs: request while waiting, ready only in RESP.
  always_comb begin
    io_bus.o_mem_req     = (r_state == I_REQ) |
                           (r_state == D_REQ);
    io_bus.o_instr_ready = (r_state == RESP) & ~r_win_d;
    io_bus.o_data_ready  = (r_state == RESP) & r_win_d;
    io_bus.o_mem_we      = r_mem_we;
    io_bus.o_mem_ctrl    = r_mem_ctrl;
    io_bus.o_mem_addr    = r_mem_addr;
    io_bus.o_mem_wdata   = r_mem_wdata;
    io_bus.o_instr_data  = r_instr_data;
    io_bus.o_data_rd     = r_data_rd;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Transaction-level model predicts winner, fields and data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit          pi, dr, dw;
  logic [31:0] ia, da, dwd;
  logic [1:0]  dc;
  bit          m_last_d;
  logic [31:0] m_idata, m_drd;
  bit          w;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_inst_rd_en = pi;
    bus.i_inst_addr  = ia;
    bus.i_data_rd_en = dr;
    bus.i_data_wr_en = dw;
    bus.i_data_ctrl  = dc;
    bus.i_data_addr  = da;
    bus.i_data_wr    = dwd;
  endtask

  function automatic bit pick_d();
    if (!(dr || dw)) return 1'b0;
    if (!pi) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_idle(string tag);
    chk({tag, "_req"}, bus.o_mem_req, 0);
    chk({tag, "_irdy"}, bus.o_instr_ready, 0);
    chk({tag, "_drdy"}, bus.o_data_ready, 0);
    chk({tag, "_idat"}, bus.o_instr_data, m_idata);
    chk({tag, "_drd"}, bus.o_data_rd, m_drd);
  endtask

  // Entry/exit: just after a negedge with the FSM in IDLE.
  task automatic serve(input int dly, input logic [31:0] rd,
                       input bit drop, output bit wd);
    bit          e_we;
    logic [1:0]  e_c;
    logic [31:0] e_a, e_w;
    wd = pick_d();
    m_last_d = wd;
    if (wd) begin
      e_we = dw; e_c = dc; e_a = da; e_w = dwd;
    end else begin
      e_we = 1'b0; e_c = SZ_WORD; e_a = ia; e_w = '0;
    end
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      chk("mem_req", bus.o_mem_req, 1);
      chk("mem_we", bus.o_mem_we, e_we);
      chk("mem_ctrl", bus.o_mem_ctrl, e_c);
      chk("mem_addr", bus.o_mem_addr, e_a);
      if (e_we) chk("mem_wdata", bus.o_mem_wdata, e_w);
      chk("early_irdy", bus.o_instr_ready, 0);
      chk("early_drdy", bus.o_data_ready, 0);
      if (k == 0 && drop) begin
        if (wd) begin
          dr = 0; dw = 0; da = $urandom; dwd = $urandom;
        end else begin
          pi = 0; ia = $urandom;
        end
        drive();
      end
      if (k == dly) begin
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = rd;
      end
    end
    @(negedge clk);
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = $urandom;
    if (wd) m_drd = rd;
    else m_idata = rd;
    chk("resp_req", bus.o_mem_req, 0);
    chk("resp_irdy", bus.o_instr_ready, {31'b0, !wd});
    chk("resp_drdy", bus.o_data_ready, {31'b0, wd});
    chk("resp_idat", bus.o_instr_data, m_idata);
    chk("resp_drd", bus.o_data_rd, m_drd);
    if (wd) begin
      dr = 0; dw = 0;
    end else begin
      pi = 0;
    end
    drive();
    @(negedge clk);
    chk_idle("post");
  endtask

  initial begin
    pi = 0; dr = 0; dw = 0;
    ia = '0; da = '0; dwd = '0; dc = SZ_WORD;
    m_last_d = 0; m_idata = '0; m_drd = '0;
    drive();
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_we", bus.o_mem_we, 0);
    chk("rst_ctrl", bus.o_mem_ctrl, 0);
    chk("rst_addr", bus.o_mem_addr, 0);
    chk("rst_wdata", bus.o_mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch, ack two cycles after the request.
    pi = 1; ia = 32'h0000_0010; drive();
    serve(1, 32'h0000_0013, 0, w);

    // Word write with a 4-cycle wait.
    dw = 1; da = 32'h100; dwd = 32'hDEAD_BEEF; dc = SZ_WORD;
    drive();
    serve(4, $urandom, 0, w);

    // Simultaneous fetch and read.
    pi = 1; ia = 32'h20;
    dr = 1; da = 32'h200; dc = SZ_WORD;
    drive();
    serve(2, $urandom, 0, w);
    serve(1, $urandom, 0, w);

    // Contention held across four grants.
    for (int t = 0; t < 4; t++) begin
      pi = 1; ia = 32'h40 + t * 4;
      if (!(dr || dw)) begin
        dr = 1; da = 32'h400 + t * 4; dc = SZ_HALF;
      end
      drive();
      serve(0, $urandom, 0, w);
    end
    pi = 0; dr = 0; dw = 0; drive();
    @(negedge clk);

    // Read and write both high is a byte write.
    dr = 1; dw = 1; da = 32'h503; dwd = 32'h0000_00A5;
    dc = SZ_BYTE; drive();
    serve(1, $urandom, 0, w);

    // Requester drops mid-transaction.
    pi = 1; ia = 32'h600; drive();
    serve(2, 32'h1234_5678, 1, w);
    dr = 1; da = 32'h700; dc = SZ_WORD; drive();
    serve(3, 32'h8765_4321, 1, w);

    // Randomized traffic.
    repeat (40) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!(dr || dw) && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: begin dr = 1; dw = 0; end
          1: begin dr = 0; dw = 1; end
          default: begin dr = 1; dw = 1; end
        endcase
        da = $urandom; dwd = $urandom;
        dc = 2'($urandom_range(0, 2));
      end
      if (!pi && !(dr || dw)) begin
        pi = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      drive();
      serve($urandom_range(0, 3), $urandom,
            $urandom_range(0, 4) == 0, w);
    end
    pi = 0; dr = 0; dw = 0; drive();
    @(negedge clk);

    // Reset during D_REQ, then a stale ack.
    dr = 1; da = 32'h300; dc = SZ_WORD; drive();
    @(negedge clk);
    chk("pre_rst_req", bus.o_mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bus.o_mem_req, 0);
    chk("arst_drdy", bus.o_data_ready, 0);
    m_last_d = 0; m_idata = '0; m_drd = '0;
    dr = 0; drive();
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_idle("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("stale_ack");
    bus.i_mem_ack = 1'b0;
    @(negedge clk);
    chk_idle("after_rst");

    // IDLE after release: fetch granted with normal latency.
    pi = 1; ia = 32'h0000_0800; drive();
    serve(0, 32'hCAFE_F00D, 0, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 i_inst_rd_en  in  1  instruction-fetch read request, held until o_instr_ready.
REQ-004 i_inst_addr  in  32  fetch address.
REQ-005 o_instr_ready  out  1  one-cycle pulse: fetch complete, o_instr_data valid.
REQ-006 o_instr_data  out  32 (dataBus_t)  fetched instruction word.
REQ-007 i_data_rd_en  in  1  data read request, held until o_data_ready.
REQ-008 i_data_wr_en  in  1  data write request, held until o_data_ready.
REQ-009 i_data_ctrl  in  2  access size, byte/half/word encoding from the shared package.
REQ-010 i_data_addr  in  32 (dataBus_t)  data address.
REQ-011 i_data_wr  in  32 (dataBus_t)  write data.
REQ-012 o_data_ready  out  1  one-cycle pulse: data access complete.
REQ-013 o_data_rd  out  32 (dataBus_t)  read data, valid with o_data_ready.
REQ-014 o_mem_req  out  1  unified memory request, held until i_mem_ack.
REQ-015 o_mem_we  out  1  1 = write, 0 = read.
REQ-016 o_mem_ctrl  out  2  access size (word for fetches).
REQ-017 o_mem_addr / o_mem_wdata  out  32 each  address and write data; stable while o_mem_req = 1.
REQ-018 i_mem_ack  in  1  memory completes the current request; ignored while o_mem_req = 0.
REQ-019 i_mem_rdata  in  32  read data, valid in the i_mem_ack cycle.

Function
REQ-020 The FSM SHALL have four states: IDLE, I_REQ, D_REQ, RESP; exactly one transaction is outstanding at any time.
REQ-021 In IDLE, a pending request SHALL move the FSM to I_REQ or D_REQ at the next edge, with o_mem_* registered from the requester's inputs.
REQ-022 I_REQ/D_REQ SHALL hold o_mem_req = 1 with stable fields until i_mem_ack, then go to RESP and capture i_mem_rdata.
REQ-023 RESP SHALL pulse the winner's ready for exactly one cycle with the captured data, then return to IDLE; no grant is made in RESP.
REQ-024 Latency: request seen in IDLE at cycle N, o_mem_req from N+1, ack at cycle M ≥ N+1, ready at M+1; minimum 3 cycles per transaction.
REQ-025 Simultaneous fetch and data requests in IDLE: data SHALL win (default arbitration).
REQ-026 i_data_rd_en and i_data_wr_en both high: treated as a write.
REQ-027 A requester dropping its request mid-transaction SHALL NOT abort it; the memory cycle completes and the ready pulse still occurs.
REQ-028 o_mem_ctrl SHALL be word for fetches and i_data_ctrl for data accesses; o_mem_we = 0 for fetches.
REQ-029 Ready outputs SHALL be 0 outside RESP; data outputs hold their last captured value.

Reset
REQ-030 Asynchronous reset SHALL force IDLE, with o_mem_req, o_mem_we, o_instr_ready and o_data_ready at 0 and all data/address/ctrl outputs at 0.
REQ-031 Reset during I_REQ/D_REQ SHALL drop o_mem_req immediately; a later i_mem_ack for the aborted request is ignored.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester that did not win the previous grant (pointer resets to favour data); without it, fixed data priority per REQ-025.

Structure
REQ-033 The shared package SHALL hold arb_state_t (enum of the four states) and the access-size encodings; dataBus_t comes from the shared package.
REQ-034 The block SHALL be a single module with no sub-module.

Verification
REQ-035 Fetch only: addr 0x0000_0010 at N, ack at N+2 with rdata 0x0000_0013 -> o_instr_ready at N+3 with o_instr_data 0x0000_0013.
REQ-036 Write: addr 0x100, wdata 0xDEAD_BEEF, ctrl word, ack delayed 4 cycles -> o_mem_we = 1 and fields stable for all 4 wait cycles; o_data_ready one cycle after ack.
REQ-037 Simultaneous fetch (0x20) and read (0x200), macro off -> data granted first, then fetch; two ready pulses in that order.
REQ-038 Same stimulus held for 4 transactions, ARB_ROUND_ROBIN_EN defined -> grants alternate D, I, D, I.
REQ-039 rst_n low during D_REQ, then ack asserted -> o_mem_req = 0 immediately, no o_data_ready, FSM in IDLE after release.
